// File: rtl/sar_comp_responder.sv
// Comparator-side responder for SAR closed-loop testing: tracks/holds vin, returns one decision per DAC code.
// Optional COMP_OFFSET_EN adds a signed 4-bit comparator offset port (ofs) with saturation.
// state    | meaning
// IDLE     | waiting for ena
// TRACK    | following vin, timer counts down the track phase
// HOLD     | sample held, waiting for a DAC trial code
// SETTLE   | DAC settling, decision at terminal count
module sar_comp_responder #(
  parameter int N         = 6,
  parameter int TRACK_CYC = 2,
  parameter int SETTLE    = 2
) (
  input  logic         clk,
  input  logic         rest_n,
  input  logic         ena,
  input  logic [N-1:0] vin,
  input  logic [N-1:0] dac,
  input  logic         dac_load,
`ifdef COMP_OFFSET_EN
  input  logic [3:0]   ofs,
`endif
  output logic         comp,
  output logic         comp_vld,
  output logic         sample_done,
  output logic         busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
  localparam logic [3:0] TRACK_LD  = 4'(TRACK_CYC - 1);
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  typedef enum logic [1:0] {S_IDLE, S_TRACK, S_HOLD, S_SETTLE} state_t;

  state_t         state, state_nxt;
  logic [3:0]     timer, timer_nxt;
  logic [N-1:0]   vin_hold, vin_hold_nxt;
  logic [N-1:0]   dac_q, dac_q_nxt;
  logic [CW-1:0]  bit_cnt, bit_cnt_nxt;
  logic           comp_nxt, comp_vld_nxt, sample_done_nxt, busy_nxt;
  logic [N-1:0]   vin_adj;
  logic           decide;

`ifdef COMP_OFFSET_EN
  // Offset applied in N+2 bits so both underflow and overflow are visible before clamping.
  logic [N+1:0] sum;
  always_comb begin
    sum = {2'b00, vin_hold} + {{(N-2){ofs[3]}}, ofs};
    if (sum[N+1])  vin_adj = '0;
    else if (sum[N]) vin_adj = '1;
    else           vin_adj = sum[N-1:0];
  end
`else
  assign vin_adj = vin_hold;
`endif

  assign decide = (vin_adj >= dac_q);

  always_ff @(posedge clk or negedge rest_n) begin
    if (!rest_n) begin
      state       <= S_IDLE;
      timer       <= '0;
      vin_hold    <= '0;
      dac_q       <= '0;
      bit_cnt     <= '0;
      comp        <= 1'b0;
      comp_vld    <= 1'b0;
      sample_done <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      vin_hold    <= vin_hold_nxt;
      dac_q       <= dac_q_nxt;
      bit_cnt     <= bit_cnt_nxt;
      comp        <= comp_nxt;
      comp_vld    <= comp_vld_nxt;
      sample_done <= sample_done_nxt;
      busy        <= busy_nxt;
    end
  end

  // Priority in active states: abort, then dac_load restart, then terminal count.
  always_comb begin
    state_nxt       = state;
    timer_nxt       = timer;
    vin_hold_nxt    = vin_hold;
    dac_q_nxt       = dac_q;
    bit_cnt_nxt     = bit_cnt;
    comp_nxt        = comp;
    comp_vld_nxt    = 1'b0;
    sample_done_nxt = 1'b0;
    busy_nxt        = busy;
    if (state != S_IDLE && !ena) begin
      state_nxt   = S_IDLE;
      busy_nxt    = 1'b0;
      bit_cnt_nxt = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (ena) begin
            state_nxt   = S_TRACK;
            busy_nxt    = 1'b1;
            timer_nxt   = TRACK_LD;
            bit_cnt_nxt = '0;
          end
        end
        S_TRACK: begin
          vin_hold_nxt = vin;
          if (timer == 4'd0) begin
            state_nxt       = S_HOLD;
            sample_done_nxt = 1'b1;
          end else begin
            timer_nxt = timer - 4'd1;
          end
        end
        S_HOLD: begin
          if (dac_load) begin
            dac_q_nxt = dac;
            timer_nxt = SETTLE_LD;
            state_nxt = S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (dac_load) begin
            dac_q_nxt = dac;
            timer_nxt = SETTLE_LD;
          end else if (timer == 4'd0) begin
            comp_nxt     = decide;
            comp_vld_nxt = 1'b1;
            if (bit_cnt == LAST_BIT) begin
              state_nxt   = S_IDLE;
              busy_nxt    = 1'b0;
              bit_cnt_nxt = '0;
            end else begin
              state_nxt   = S_HOLD;
              bit_cnt_nxt = bit_cnt + CW'(1);
            end
          end else begin
            timer_nxt = timer - 4'd1;
          end
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_comp_responder.sv
// Bench for sar_comp_responder: randomized conversions checked against an arithmetic reference model.
// Build with COMP_OFFSET_EN defined to exercise the offset port.
module tb_sar_comp_responder;
  localparam int N         = 6;
  localparam int TRACK_CYC = 2;
  localparam int SETTLE    = 2;
  localparam int MAXV      = (1 << N) - 1;
`ifdef COMP_OFFSET_EN
  localparam bit OFS_EN = 1'b1;
`else
  localparam bit OFS_EN = 1'b0;
`endif

  logic clk = 1'b0, rest_n = 1'b0, ena = 1'b0, dac_load = 1'b0;
  logic [N-1:0] vin = '0, dac = '0;
`ifdef COMP_OFFSET_EN
  logic [3:0] ofs = 4'd0;
`endif
  logic comp, comp_vld, sample_done, busy;
  int pass_cnt = 0, total_cnt = 0;
  int cur_ofs = 0;

  sar_comp_responder #(.N(N), .TRACK_CYC(TRACK_CYC), .SETTLE(SETTLE)) dut (
    .clk(clk), .rest_n(rest_n), .ena(ena), .vin(vin), .dac(dac), .dac_load(dac_load),
`ifdef COMP_OFFSET_EN
    .ofs(ofs),
`endif
    .comp(comp), .comp_vld(comp_vld), .sample_done(sample_done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference decision: held level plus optional offset, clamped to the code range.
  function automatic bit model_comp(int vh, int d, int o);
    int s;
    s = OFS_EN ? vh + o : vh;
    if (s < 0) s = 0;
    if (s > MAXV) s = MAXV;
    return s >= d;
  endfunction

  function automatic int rnd(int lo, int hi);
    return lo + int'($urandom_range(0, hi - lo));
  endfunction

  task automatic set_ofs(input int o);
    cur_ofs = o;
`ifdef COMP_OFFSET_EN
    ofs = o[3:0];
`endif
  endtask

  task automatic start_conv(input int v, input bit rnd_track, output int held, output int lat);
    int t;
    ena = 1'b1;
    vin = v[N-1:0];
    held = v;
    @(negedge clk);
    lat = 0;
    while (sample_done !== 1'b1 && lat <= 40) begin
      if (rnd_track) begin
        t = rnd(0, MAXV);
        vin = t[N-1:0];
      end
      held = int'(vin);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_bit(input int d, output bit c, output int lat);
    dac = d[N-1:0];
    dac_load = 1'b1;
    @(negedge clk);
    dac_load = 1'b0;
    lat = 0;
    while (comp_vld !== 1'b1 && lat <= 40) begin
      @(negedge clk);
      lat++;
    end
    c = comp;
  endtask

  task automatic go_idle();
    ena = 1'b0;
    dac_load = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    int held, lat; bit c, seen;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({comp, comp_vld, sample_done, busy} !== 4'b0000)
      $display("FAIL reset_outputs: got %b, expected 0000", {comp, comp_vld, sample_done, busy});
    else pass_cnt++;
    rest_n = 1'b1;
    @(negedge clk);
    dac_load = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dac_load = 1'b0;
      if (comp_vld !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL idle_dac_load_ignored: got activity %b, expected 0", seen);
    else pass_cnt++;
    set_ofs(0);
    start_conv(63, 1'b0, held, lat);
    do_bit(0, c, lat);
    total_cnt++;
    if (c !== 1'b1) $display("FAIL pre_reset_comp: got %b, expected 1", c);
    else pass_cnt++;
    dac = 6'd5;
    dac_load = 1'b1;
    @(negedge clk);
    dac_load = 1'b0;
    #2 rest_n = 1'b0;
    #1;
    total_cnt++;
    if ({comp, comp_vld, sample_done, busy} !== 4'b0000)
      $display("FAIL async_reset_mid_settle: got %b, expected 0000", {comp, comp_vld, sample_done, busy});
    else pass_cnt++;
    ena = 1'b0;
    @(negedge clk);
    rest_n = 1'b1;
    repeat (2) @(negedge clk);
    start_conv(20, 1'b0, held, lat);
    total_cnt++;
    if (lat !== TRACK_CYC) $display("FAIL idle_after_reset_track_lat: got %0d, expected %0d", lat, TRACK_CYC);
    else pass_cnt++;
    go_idle();
  endtask

  task automatic test_timing();
    int held, lat, d, t; bit c;
    set_ofs(0);
    for (int i = 0; i < 4; i++) begin
      start_conv(rnd(0, MAXV), 1'b1, held, lat);
      total_cnt++;
      if (lat !== TRACK_CYC) $display("FAIL track_lat: got %0d, expected %0d", lat, TRACK_CYC);
      else pass_cnt++;
      t = rnd(0, MAXV);
      vin = t[N-1:0];
      @(negedge clk);
      total_cnt++;
      if (sample_done !== 1'b0) $display("FAIL sample_done_pulse: got %b, expected 0", sample_done);
      else pass_cnt++;
      d = rnd(0, MAXV);
      do_bit(d, c, lat);
      total_cnt++;
      if (lat !== SETTLE) $display("FAIL settle_lat: got %0d, expected %0d", lat, SETTLE);
      else pass_cnt++;
      total_cnt++;
      if (c !== model_comp(held, d, cur_ofs))
        $display("FAIL held_sample_comp: got %b, expected %b (held %0d dac %0d)", c, model_comp(held, d, cur_ofs), held, d);
      else pass_cnt++;
      go_idle();
    end
  endtask

  task automatic test_full_conv();
    int held, lat, v, code, trial; bit c, e; logic [N-1:0] seq;
    for (int i = 0; i < 5; i++) begin
      v = (i == 0) ? 37 : rnd(0, MAXV);
      set_ofs((i == 0) ? 0 : rnd(0, 15) - 8);
      start_conv(v, 1'b0, held, lat);
      code = 0;
      seq = '0;
      for (int b = N - 1; b >= 0; b--) begin
        trial = code | (1 << b);
        e = model_comp(v, trial, cur_ofs);
        do_bit(trial, c, lat);
        seq[b] = c;
        total_cnt++;
        if (c !== e) $display("FAIL conv_bit: vin %0d bit %0d got %b, expected %b", v, b, c, e);
        else pass_cnt++;
        total_cnt++;
        if (busy !== (b != 0)) $display("FAIL conv_busy: bit %0d got %b, expected %b", b, busy, (b != 0));
        else pass_cnt++;
        if (e) code = trial;
      end
      ena = 1'b0;
      if (i == 0) begin
        total_cnt++;
        if (seq !== 6'b100101) $display("FAIL conv37_sequence: got %b, expected 100101", seq);
        else pass_cnt++;
      end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_boundaries();
    int vins[3] = '{0, 63, 62};
    int dacs[3] = '{0, 63, 63};
    int held, lat; bit c;
    set_ofs(0);
    for (int i = 0; i < 3; i++) begin
      start_conv(vins[i], 1'b0, held, lat);
      do_bit(dacs[i], c, lat);
      total_cnt++;
      if (c !== model_comp(vins[i], dacs[i], 0))
        $display("FAIL boundary: vin %0d dac %0d got %b, expected %b", vins[i], dacs[i], c, model_comp(vins[i], dacs[i], 0));
      else pass_cnt++;
      go_idle();
    end
  endtask

  task automatic test_restart();
    int held, lat, v, d1, d2, pulses, at; bit cv;
    set_ofs(0);
    for (int r = 0; r < 3; r++) begin
      v = rnd(0, MAXV); d1 = rnd(0, MAXV); d2 = rnd(0, MAXV);
      start_conv(v, 1'b0, held, lat);
      dac = d1[N-1:0]; dac_load = 1'b1;
      @(negedge clk);
      dac = d2[N-1:0]; dac_load = 1'b1;
      @(negedge clk);
      dac_load = 1'b0;
      pulses = 0; at = -1; cv = 1'b0;
      for (int i = 0; i < SETTLE + 4; i++) begin
        if (comp_vld === 1'b1) begin
          pulses++;
          if (at < 0) begin at = i; cv = comp; end
        end
        @(negedge clk);
      end
      total_cnt++;
      if (pulses !== 1) $display("FAIL restart_pulses: got %0d, expected 1", pulses);
      else pass_cnt++;
      total_cnt++;
      if (at !== SETTLE) $display("FAIL restart_lat: got %0d, expected %0d", at, SETTLE);
      else pass_cnt++;
      total_cnt++;
      if (cv !== model_comp(v, d2, 0)) $display("FAIL restart_comp: got %b, expected %b", cv, model_comp(v, d2, 0));
      else pass_cnt++;
      go_idle();
    end
  endtask

  task automatic test_abort();
    int held, lat, v; bit c, seen;
    set_ofs(0);
    v = rnd(1, MAXV - 1);
    start_conv(v, 1'b0, held, lat);
    do_bit(0, c, lat);
    ena = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL abort_hold_busy: got %b, expected 0", busy);
    else pass_cnt++;
    seen = 1'b0;
    dac = v[N-1:0] + 6'd1; dac_load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      dac_load = 1'b0;
      if (comp_vld !== 1'b0 || sample_done !== 1'b0) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL abort_hold_no_pulse: got %b, expected 0", seen);
    else pass_cnt++;
    total_cnt++;
    if (comp !== 1'b1) $display("FAIL abort_hold_comp_kept: got %b, expected 1", comp);
    else pass_cnt++;
    start_conv(v, 1'b0, held, lat);
    do_bit(0, c, lat);
    dac = v[N-1:0] + 6'd1; dac_load = 1'b1;
    @(negedge clk);
    dac_load = 1'b0;
    repeat (SETTLE - 1) @(negedge clk);
    ena = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (comp_vld !== 1'b0) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL abort_decide_no_vld: got %b, expected 0", seen);
    else pass_cnt++;
    total_cnt++;
    if ({comp, busy} !== 2'b10) $display("FAIL abort_decide_state: got comp,busy=%b, expected 10", {comp, busy});
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int held, lat, v, code, trial; bit c;
    set_ofs(0);
    v = rnd(0, MAXV);
    start_conv(v, 1'b0, held, lat);
    code = 0;
    for (int b = N - 1; b >= 0; b--) begin
      trial = code | (1 << b);
      do_bit(trial, c, lat);
      if (model_comp(v, trial, 0)) code = trial;
    end
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL b2b_busy_low: got %b, expected 0", busy);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL b2b_restart_busy: got %b, expected 1", busy);
    else pass_cnt++;
    lat = 0;
    while (sample_done !== 1'b1 && lat <= 40) begin
      @(negedge clk);
      lat++;
    end
    total_cnt++;
    if (lat !== TRACK_CYC) $display("FAIL b2b_track_lat: got %0d, expected %0d", lat, TRACK_CYC);
    else pass_cnt++;
    go_idle();
  endtask

`ifdef COMP_OFFSET_EN
  task automatic test_offset();
    int vins[2] = '{10, 62};
    int ofss[2] = '{-3, 7};
    int dacs[2] = '{8, 63};
    int held, lat; bit c;
    for (int i = 0; i < 2; i++) begin
      set_ofs(ofss[i]);
      start_conv(vins[i], 1'b0, held, lat);
      do_bit(dacs[i], c, lat);
      total_cnt++;
      if (c !== model_comp(vins[i], dacs[i], ofss[i]))
        $display("FAIL offset: vin %0d ofs %0d dac %0d got %b, expected %b", vins[i], ofss[i], dacs[i], c, model_comp(vins[i], dacs[i], ofss[i]));
      else pass_cnt++;
      go_idle();
    end
    set_ofs(0);
  endtask
`endif

  initial begin
    test_reset();
    test_timing();
    test_full_conv();
    test_boundaries();
    test_restart();
    test_abort();
    test_back_to_back();
`ifdef COMP_OFFSET_EN
    test_offset();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
